// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory request
// at a time and presents the returned word in an IF/ID register with a
// one-entry skid buffer behind it. Branch/jump redirects flush and refetch.
//
// Handshake rules: a request transfers on a cycle where imem_req_valid and
// imem_req_ready are both high at the rising edge; while valid is high and
// ready is low, imem_req_addr stays stable. The IF/ID entry is consumed on a
// cycle where if_valid is high and stall is low.
module fetch_stage #(
    parameter int unsigned      PC_W      = 64,
    parameter logic [PC_W-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            if_valid,
    output logic [PC_W-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_SKID  = 2'd3
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   skid_pc;
    logic [31:0]       skid_instr;

    logic              consume;
    logic              req_fire;
    logic              outstanding;
    logic [PC_W-1:0]   pc_plus4;
    logic [PC_W-1:0]   redirect_tgt;

    // Handshake qualifiers and next-PC candidates.
    always_comb begin
        consume        = if_valid && !stall;
        imem_req_valid = !reset && (state == S_REQ) && !redirect_valid
                         && (!if_valid || !stall);
        req_fire       = imem_req_valid && imem_req_ready;
        // A request is still in flight if its response has not shown up yet.
        outstanding    = ((state == S_WAIT) || (state == S_DRAIN)) && !imem_resp_valid;
        pc_plus4       = pc + PC_W'(4);
        redirect_tgt   = {redirect_pc[PC_W-1:2], 2'b00};
        imem_req_addr  = pc;
        state_dbg      = state;
    end

    // Fetch FSM, PC, IF/ID register and skid buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            if_valid   <= 1'b0;
            if_instr   <= NOP_INSTR;
            if_pc      <= '0;
            skid_pc    <= '0;
            skid_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            // Redirect wins over stall and any response arriving this cycle.
            if_valid   <= 1'b0;
            if_instr   <= NOP_INSTR;
            skid_pc    <= '0;
            skid_instr <= NOP_INSTR;
            pc         <= redirect_tgt;
            state      <= outstanding ? S_DRAIN : S_REQ;
        end else begin
            // Default: a consumed entry empties unless something refills it below.
            if (consume) begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
            end
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        pc <= pc_plus4;
                        if (!if_valid || consume) begin
                            if_valid <= 1'b1;
                            if_instr <= imem_resp_data;
                            if_pc    <= pc;
                            state    <= S_REQ;
                        end else begin
                            skid_instr <= imem_resp_data;
                            skid_pc    <= pc;
                            state      <= S_SKID;
                        end
                    end
                end
                S_SKID: begin
                    if (consume) begin
                        if_valid <= 1'b1;
                        if_instr <= skid_instr;
                        if_pc    <= skid_pc;
                        state    <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    // Response belongs to a flushed fetch; drop it.
                    if (imem_resp_valid) begin
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule
